// File: rtl/uart_multi_pkg.sv
// Shared definitions for the multi-channel UART register wrapper.
//   - state_t      : register transaction sequencer states
//   - GLB_BLK      : block select value of the global register block
//   - OFF_*        : register offsets inside the global block
//   - VERSION      : wrapper version reported through INFO
//   - info_word()  : composes the read-only INFO register value
package uart_multi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        TURN   = 2'd3
    } state_t;

    localparam logic [2:0] GLB_BLK      = 3'd7;

    localparam logic [3:0] OFF_IRQ_STAT = 4'd0;
    localparam logic [3:0] OFF_IRQ_MASK = 4'd1;
    localparam logic [3:0] OFF_UART_RST = 4'd2;
    localparam logic [3:0] OFF_INFO     = 4'd3;

    localparam logic [7:0] VERSION      = 8'h01;

    function automatic logic [31:0] info_word(input int num_uart);
        return {16'h0, VERSION, 4'h0, 4'(num_uart)};
    endfunction

endpackage

// File: rtl/uart_core.sv
// Minimal 8N1 UART channel with a small register interface.
// Register map (off):
//   0 SCRATCH  read/write
//   1 TXDATA   write starts a frame when the transmitter is idle
//   2 STATUS   {6'b0, rx_valid, tx_busy}
//   3 RXDATA   last received byte; reading clears rx_valid
// A request is acknowledged with a one-cycle ack the cycle after cs rises.
// Ports:
//   app_clk        : clock
//   arst_n         : channel reset, active low, sampled on app_clk
//   cs/wr/off      : request, direction, register offset
//   wdata/be       : write byte and its byte enable
//   ack/rdata      : response strobe and read byte (0 for writes)
//   rxd/txd        : serial lines
module uart_core
    import uart_multi_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       app_clk,
    input  logic       arst_n,
    input  logic       cs,
    input  logic       wr,
    input  logic [3:0] off,
    input  logic [7:0] wdata,
    input  logic       be,
    output logic       ack,
    output logic [7:0] rdata,
    input  logic       rxd,
    output logic       txd
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2 - 1);

    logic          ack_reg;
    logic [7:0]    rdata_reg;
    logic [7:0]    scratch_reg;
    logic [9:0]    tx_shift_reg;
    logic [3:0]    tx_bits_reg;
    logic [DW-1:0] tx_div_reg;
    logic [1:0]    rx_sync_reg;
    logic          rx_busy_reg;
    logic [3:0]    rx_bits_reg;
    logic [DW-1:0] rx_div_reg;
    logic [7:0]    rx_shift_reg;
    logic [7:0]    rx_data_reg;
    logic          rx_valid_reg;

    logic access;
    logic tx_busy;
    logic rx_in;

    // Holding cs across the ack cycle must not execute the access twice.
    assign access  = cs & ~ack_reg;
    assign tx_busy = (tx_bits_reg != 4'd0);
    assign rx_in   = rx_sync_reg[1];

    always_ff @(posedge app_clk) begin
        if (!arst_n) begin
            ack_reg      <= 1'b0;
            rdata_reg    <= '0;
            scratch_reg  <= '0;
            tx_shift_reg <= '1;
            tx_bits_reg  <= '0;
            tx_div_reg   <= '0;
            rx_sync_reg  <= '1;
            rx_busy_reg  <= 1'b0;
            rx_bits_reg  <= '0;
            rx_div_reg   <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            ack_reg     <= access;
            rx_sync_reg <= {rx_sync_reg[0], rxd};

            // Transmitter: shift one bit per CLK_DIV cycles, idle level is 1.
            if (tx_busy) begin
                if (tx_div_reg == DIV_LAST) begin
                    tx_div_reg   <= '0;
                    tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
                    tx_bits_reg  <= tx_bits_reg - 4'd1;
                end else begin
                    tx_div_reg <= tx_div_reg + DW'(1);
                end
            end

            if (access) begin
                if (wr) begin
                    rdata_reg <= '0;
                end else begin
                    case (off)
                        4'd0:    rdata_reg <= scratch_reg;
                        4'd2:    rdata_reg <= {6'b0, rx_valid_reg, tx_busy};
                        4'd3:    rdata_reg <= rx_data_reg;
                        default: rdata_reg <= '0;
                    endcase
                    if (off == 4'd3) begin
                        rx_valid_reg <= 1'b0;
                    end
                end
                if (wr && be) begin
                    if (off == 4'd0) begin
                        scratch_reg <= wdata;
                    end
                    if (off == 4'd1 && !tx_busy) begin
                        tx_shift_reg <= {1'b1, wdata, 1'b0};
                        tx_bits_reg  <= 4'd10;
                        tx_div_reg   <= '0;
                    end
                end
            end

            // Receiver: start bit verified mid-bit, then 8 data bits and stop.
            if (!rx_busy_reg) begin
                if (!rx_in) begin
                    rx_busy_reg <= 1'b1;
                    rx_div_reg  <= '0;
                    rx_bits_reg <= '0;
                end
            end else if (rx_div_reg == ((rx_bits_reg == 4'd0) ? DIV_HALF : DIV_LAST)) begin
                rx_div_reg <= '0;
                if (rx_bits_reg == 4'd0) begin
                    if (rx_in) begin
                        rx_busy_reg <= 1'b0;
                    end else begin
                        rx_bits_reg <= 4'd1;
                    end
                end else if (rx_bits_reg == 4'd9) begin
                    rx_busy_reg <= 1'b0;
                    if (rx_in) begin
                        rx_data_reg  <= rx_shift_reg;
                        rx_valid_reg <= 1'b1;
                    end
                end else begin
                    rx_shift_reg <= {rx_in, rx_shift_reg[7:1]};
                    rx_bits_reg  <= rx_bits_reg + 4'd1;
                end
            end else begin
                rx_div_reg <= rx_div_reg + DW'(1);
            end
        end
    end

    assign ack   = ack_reg;
    assign rdata = rdata_reg;
    assign txd   = tx_shift_reg[0];

endmodule

// File: rtl/uart_rx_act_det.sv
// RX activity detector for one UART line.
// Two-flop synchroniser on the asynchronous serial input followed by a
// 1->0 edge detector; fall is a single-cycle pulse per start-bit edge.
// Ports:
//   app_clk : clock
//   reset   : synchronous active-high reset (line assumed idle high)
//   rxd     : asynchronous serial input
//   fall    : one-cycle pulse on a synchronised falling edge
module uart_rx_act_det
    import uart_multi_pkg::*;
(
    input  logic app_clk,
    input  logic reset,
    input  logic rxd,
    output logic fall
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge app_clk) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign fall = prev_reg & ~sync2_reg;

endmodule

// File: rtl/uart_multi_wrapper.sv
// N-channel UART aggregator on the register bus.
// A sequencer (IDLE -> ACCESS -> RESP -> TURN) latches each request, routes
// it to one uart_core channel or the global block, and returns a one-cycle
// reg_ack with reg_err set on decode error or channel ack timeout.
// Global block (sel = 7): IRQ_STAT (W1C), IRQ_MASK, UART_RST (per-channel
// soft reset, all set after reset), INFO (read-only).
// Ports:
//   app_clk, reset                      : clock, synchronous active-high reset
//   reg_cs/reg_wr/reg_addr/reg_wdata/reg_be : register request
//   reg_rdata/reg_ack/reg_err           : register response
//   uart_rxd/uart_txd                   : per-channel serial lines
//   uart_irq                            : registered OR of IRQ_STAT & IRQ_MASK
module uart_multi_wrapper
    import uart_multi_pkg::*;
#(
    parameter int NUM_UART = 4,
    parameter int ACK_TMO  = 32
) (
    input  logic                app_clk,
    input  logic                reset,
    input  logic                reg_cs,
    input  logic                reg_wr,
    input  logic [10:0]         reg_addr,
    input  logic [31:0]         reg_wdata,
    input  logic [3:0]          reg_be,
    output logic [31:0]         reg_rdata,
    output logic                reg_ack,
    output logic                reg_err,
    input  logic [NUM_UART-1:0] uart_rxd,
    output logic [NUM_UART-1:0] uart_txd,
    output logic                uart_irq
);

    localparam logic [3:0] NUM_U4   = 4'(NUM_UART);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);

    state_t state_reg, state_next;

    logic [2:0]          sel_reg;
    logic [3:0]          off_reg;
    logic                wr_reg;
    logic [7:0]          wdata_reg;
    logic                be_reg;
    logic [7:0]          tmo_cnt_reg;
    logic [31:0]         rdata_reg;
    logic                err_reg;
    logic [NUM_UART-1:0] irq_stat_reg;
    logic [NUM_UART-1:0] irq_mask_reg;
    logic [NUM_UART-1:0] uart_rst_reg;
    logic                irq_reg;
    logic [NUM_UART-1:0] ch_rst_n_reg;

    logic [NUM_UART-1:0] ch_cs;
    logic [NUM_UART-1:0] ch_ack;
    logic [7:0]          ch_rdata [NUM_UART];
    logic [NUM_UART-1:0] rx_fall;
    logic                ch_ack_any;
    logic [7:0]          ch_rdata_sel;
    logic                addr_valid;
    logic                cap_en;
    logic [31:0]         rdata_next;
    logic                err_next;
    logic                glb_exec;
    logic                glb_wr;
    logic [31:0]         glb_rdata;
    logic [NUM_UART-1:0] w1c_bits;
    logic                unused_inputs;

    assign unused_inputs = ^{reg_addr[10:9], reg_addr[1:0], reg_wdata[31:8], reg_be[3:1]};

    assign addr_valid = ({1'b0, reg_addr[8:6]} < NUM_U4) || (reg_addr[8:6] == GLB_BLK);

    // Channel selects come from the latched block select only.
    always_comb begin
        ch_cs = '0;
        if (state_reg == ACCESS && sel_reg != GLB_BLK) begin
            for (int i = 0; i < NUM_UART; i++) begin
                ch_cs[i] = (sel_reg == 3'(i));
            end
        end
    end

    always_comb begin
        ch_rdata_sel = '0;
        for (int i = 0; i < NUM_UART; i++) begin
            if (ch_cs[i]) begin
                ch_rdata_sel = ch_rdata_sel | ch_rdata[i];
            end
        end
    end

    assign ch_ack_any = |(ch_ack & ch_cs);

    always_comb begin
        glb_rdata = '0;
        case (off_reg)
            OFF_IRQ_STAT: glb_rdata = 32'(irq_stat_reg);
            OFF_IRQ_MASK: glb_rdata = 32'(irq_mask_reg);
            OFF_UART_RST: glb_rdata = 32'(uart_rst_reg);
            OFF_INFO:     glb_rdata = info_word(NUM_UART);
            default:      glb_rdata = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cap_en     = 1'b0;
        rdata_next = '0;
        err_next   = 1'b0;
        glb_exec   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (reg_cs) begin
                    if (addr_valid) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = RESP;
                        cap_en     = 1'b1;
                        err_next   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (sel_reg == GLB_BLK) begin
                    glb_exec   = 1'b1;
                    cap_en     = 1'b1;
                    rdata_next = wr_reg ? 32'h0 : glb_rdata;
                    state_next = RESP;
                end else if (ch_ack_any) begin
                    cap_en     = 1'b1;
                    rdata_next = {24'h0, ch_rdata_sel};
                    state_next = RESP;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    cap_en     = 1'b1;
                    err_next   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = TURN;
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign glb_wr   = glb_exec & wr_reg & be_reg;
    assign w1c_bits = (glb_wr && off_reg == OFF_IRQ_STAT) ? wdata_reg[NUM_UART-1:0] : '0;

    always_ff @(posedge app_clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge app_clk) begin
        if (reset) begin
            sel_reg      <= '0;
            off_reg      <= '0;
            wr_reg       <= 1'b0;
            wdata_reg    <= '0;
            be_reg       <= 1'b0;
            tmo_cnt_reg  <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            irq_stat_reg <= '0;
            irq_mask_reg <= '0;
            uart_rst_reg <= '1;
            irq_reg      <= 1'b0;
        end else begin
            if (state_reg == IDLE && reg_cs) begin
                sel_reg   <= reg_addr[8:6];
                off_reg   <= reg_addr[5:2];
                wr_reg    <= reg_wr;
                wdata_reg <= reg_wdata[7:0];
                be_reg    <= reg_be[0];
            end
            tmo_cnt_reg <= (state_reg == ACCESS) ? tmo_cnt_reg + 8'd1 : 8'd0;
            if (cap_en) begin
                rdata_reg <= rdata_next;
                err_reg   <= err_next;
            end
            // A new edge wins over a simultaneous write-1-to-clear.
            irq_stat_reg <= (irq_stat_reg & ~w1c_bits) | rx_fall;
            irq_reg      <= |(irq_stat_reg & irq_mask_reg);
            if (glb_wr && off_reg == OFF_IRQ_MASK) begin
                irq_mask_reg <= wdata_reg[NUM_UART-1:0];
            end
            if (glb_wr && off_reg == OFF_UART_RST) begin
                uart_rst_reg <= wdata_reg[NUM_UART-1:0];
            end
        end
    end

    // Registered channel reset keeps the reset net glitch-free.
    always_ff @(posedge app_clk) begin
        ch_rst_n_reg <= ~({NUM_UART{reset}} | uart_rst_reg);
    end

    generate
        for (genvar gi = 0; gi < NUM_UART; gi++) begin : g_ch
            uart_rx_act_det u_act (
                .app_clk (app_clk),
                .reset   (reset),
                .rxd     (uart_rxd[gi]),
                .fall    (rx_fall[gi])
            );

            uart_core u_core (
                .app_clk (app_clk),
                .arst_n  (ch_rst_n_reg[gi]),
                .cs      (ch_cs[gi]),
                .wr      (wr_reg),
                .off     (off_reg),
                .wdata   (wdata_reg),
                .be      (be_reg),
                .ack     (ch_ack[gi]),
                .rdata   (ch_rdata[gi]),
                .rxd     (uart_rxd[gi]),
                .txd     (uart_txd[gi])
            );
        end
    endgenerate

    assign reg_ack   = (state_reg == RESP);
    assign reg_err   = err_reg;
    assign reg_rdata = rdata_reg;
    assign uart_irq  = irq_reg;

endmodule

// File: tb/tb_uart_multi_wrapper.sv
module tb_uart_multi_wrapper;

    localparam int NUM_UART = 4;
    localparam int ACK_TMO  = 32;

    logic                app_clk;
    logic                reset;
    logic                reg_cs;
    logic                reg_wr;
    logic [10:0]         reg_addr;
    logic [31:0]         reg_wdata;
    logic [3:0]          reg_be;
    logic [31:0]         reg_rdata;
    logic                reg_ack;
    logic                reg_err;
    logic [NUM_UART-1:0] uart_rxd;
    logic [NUM_UART-1:0] uart_txd;
    logic                uart_irq;

    uart_multi_wrapper #(.NUM_UART(NUM_UART), .ACK_TMO(ACK_TMO)) dut (
        .app_clk   (app_clk),
        .reset     (reset),
        .reg_cs    (reg_cs),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .reg_err   (reg_err),
        .uart_rxd  (uart_rxd),
        .uart_txd  (uart_txd),
        .uart_irq  (uart_irq)
    );

    initial app_clk = 1'b0;
    always #5 app_clk = ~app_clk;

    int cyc = 0;
    always @(posedge app_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int ack_total = 0;
    int multi_cs = 0;
    logic [NUM_UART-1:0] cs_seen = '0;

    // Reference state of the register map as software sees it.
    logic [NUM_UART-1:0] m_stat;
    logic [NUM_UART-1:0] m_mask;
    logic [NUM_UART-1:0] m_rst;
    logic [7:0]          m_scr [NUM_UART];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_stat = '0;
        m_mask = '0;
        m_rst  = '1;
        for (int i = 0; i < NUM_UART; i++) m_scr[i] = 8'h00;
    endtask

    // Monitor: every reg_ack pops one expected response.
    always @(negedge app_clk) begin
        if (reg_ack === 1'b1) begin
            exp_t e;
            ack_total++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ack: reg_ack=1 with no pending request (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", reg_rdata, e.rdata);
                chk("err", {31'h0, reg_err}, {31'h0, e.err});
                chk("ack_cycle", cyc, e.cyc);
                $display("txn done: cycle=%0d rdata=%h err=%0b", cyc, reg_rdata, reg_err);
            end
        end
        if ($countones(dut.ch_cs) > 1) multi_cs++;
        cs_seen = cs_seen | dut.ch_cs;
    end

    // Issue one request at a negedge in IDLE, return at a negedge in IDLE.
    task automatic do_txn(input bit wr, input int sel, input int off, input logic [7:0] wd,
                          input bit be, input logic [NUM_UART-1:0] edge_set);
        exp_t e;
        int   lat;
        bit   got;
        logic irq_pre;
        irq_pre = |(m_stat & m_mask);
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (sel == 7) begin
            lat = 2;
            if (!wr) begin
                case (off)
                    0: e.rdata = 32'(m_stat);
                    1: e.rdata = 32'(m_mask);
                    2: e.rdata = 32'(m_rst);
                    3: e.rdata = 32'h0000_0104;
                    default: e.rdata = 32'h0;
                endcase
            end else if (be) begin
                case (off)
                    0: m_stat = m_stat & ~wd[NUM_UART-1:0];
                    1: m_mask = wd[NUM_UART-1:0];
                    2: begin
                        m_rst = wd[NUM_UART-1:0];
                        for (int i = 0; i < NUM_UART; i++) if (m_rst[i]) m_scr[i] = 8'h00;
                    end
                    default: ;
                endcase
            end
        end else if (sel < NUM_UART) begin
            if (m_rst[sel]) begin
                lat   = ACK_TMO + 1;
                e.err = 1'b1;
            end else begin
                lat = 3;
                if (!wr) e.rdata = {24'h0, m_scr[sel]};
                else if (be) m_scr[sel] = wd;
            end
        end else begin
            lat   = 1;
            e.err = 1'b1;
        end
        m_stat = m_stat | edge_set;
        e.cyc  = cyc + lat;
        exp_q.push_back(e);
        $display("txn issue: cycle=%0d wr=%0b sel=%0d off=%0d wd=%h be=%0b", cyc, wr, sel, off, wd, be);

        reg_cs    = 1'b1;
        reg_wr    = wr;
        reg_addr  = {2'($urandom), 3'(sel), 4'(off), 2'($urandom)};
        reg_wdata = {24'($urandom), wd};
        reg_be    = {3'($urandom), be};
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge app_clk);
            if (reg_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
            // Request fields change while the access is in flight.
            reg_addr  = 11'($urandom);
            reg_wdata = $urandom;
            reg_wr    = 1'($urandom);
            reg_be    = 4'($urandom);
        end
        chk("ack_wait", {31'h0, got}, 32'h1);
        if (got) chk("irq_at_resp", {31'h0, uart_irq}, {31'h0, irq_pre});
        if (!got && exp_q.size() > 0) void'(exp_q.pop_back());
        reg_cs = 1'b0;
        @(negedge app_clk);
        chk("ack_one_cycle", {31'h0, reg_ack}, 32'h0);
        chk("uart_irq", {31'h0, uart_irq}, {31'h0, |(m_stat & m_mask)});
        @(negedge app_clk);
    endtask

    task automatic pulse_rx(input int ch);
        uart_rxd[ch] = 1'b0;
        repeat (3) @(negedge app_clk);
        uart_rxd[ch] = 1'b1;
        repeat (2) @(negedge app_clk);
        m_stat[ch] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_before;
        int k;
        int kind;
        int ch;
        reset     = 1'b1;
        reg_cs    = 1'b0;
        reg_wr    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        reg_be    = '0;
        uart_rxd  = '1;
        model_reset();
        repeat (3) @(negedge app_clk);
        chk("rst_ack", {31'h0, reg_ack}, 32'h0);
        chk("rst_err", {31'h0, reg_err}, 32'h0);
        chk("rst_rdata", reg_rdata, 32'h0);
        chk("rst_irq", {31'h0, uart_irq}, 32'h0);
        reset = 1'b0;

        // INFO and reset value of UART_RST
        do_txn(0, 7, 3, 8'h00, 1, '0);
        do_txn(0, 7, 2, 8'h00, 1, '0);

        // Release channels, scratch write/read on channel 1
        do_txn(1, 7, 2, 8'h00, 1, '0);
        cs_seen = '0;
        do_txn(1, 1, 0, 8'h5A, 1, '0);
        do_txn(0, 1, 0, 8'h00, 1, '0);
        chk("cs_only_ch1", 32'(cs_seen), 32'h2);

        // Unmapped block
        cs_seen = '0;
        do_txn(0, 5, 0, 8'h00, 1, '0);
        chk("decode_no_cs", 32'(cs_seen), 32'h0);

        // Ack timeout on a channel held in soft reset, then normal access
        do_txn(1, 7, 2, 8'h04, 1, '0);
        do_txn(0, 2, 0, 8'h00, 1, '0);
        do_txn(0, 1, 0, 8'h00, 1, '0);

        // RX activity interrupt
        do_txn(1, 7, 1, 8'h01, 1, '0);
        uart_rxd[0] = 1'b0;
        k = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge app_clk);
            k = j;
            if (uart_irq === 1'b1) break;
        end
        chk("irq_within_4", {31'h0, (k <= 4 && uart_irq === 1'b1)}, 32'h1);
        m_stat[0] = 1'b1;
        uart_rxd[0] = 1'b1;
        repeat (3) @(negedge app_clk);
        do_txn(0, 7, 0, 8'h00, 1, '0);
        // New edge lands in the same cycle as the W1C
        uart_rxd[0] = 1'b0;
        @(negedge app_clk);
        do_txn(1, 7, 0, 8'h01, 1, 4'h1);
        uart_rxd[0] = 1'b1;
        repeat (3) @(negedge app_clk);
        do_txn(0, 7, 0, 8'h00, 1, '0);
        do_txn(1, 7, 0, 8'h01, 1, '0);
        do_txn(0, 7, 3, 8'h00, 1, '0);

        // Reset while a channel access is waiting for ack
        ack_before = ack_total;
        reg_cs   = 1'b1;
        reg_wr   = 1'b0;
        reg_addr = {2'b00, 3'd2, 4'd0, 2'b00};
        repeat (5) @(negedge app_clk);
        reset  = 1'b1;
        reg_cs = 1'b0;
        @(negedge app_clk);
        chk("midrst_rdata", reg_rdata, 32'h0);
        chk("midrst_irq", {31'h0, uart_irq}, 32'h0);
        reset = 1'b0;
        model_reset();
        repeat (40) @(negedge app_clk);
        chk("midrst_no_ack", ack_total - ack_before, 32'h0);
        do_txn(0, 7, 2, 8'h00, 1, '0);
        do_txn(0, 7, 1, 8'h00, 1, '0);
        do_txn(0, 7, 0, 8'h00, 1, '0);
        do_txn(1, 7, 2, 8'h00, 1, '0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1: do_txn(1, 7, $urandom_range(0, 5), 8'($urandom), ($urandom_range(0, 3) != 0), '0);
                2, 3: do_txn(0, 7, $urandom_range(0, 15), 8'h00, 1, '0);
                4, 5: do_txn(1, $urandom_range(0, NUM_UART - 1), 0, 8'($urandom), ($urandom_range(0, 3) != 0), '0);
                6, 7: do_txn(0, $urandom_range(0, NUM_UART - 1), 0, 8'h00, 1, '0);
                8:    do_txn($urandom_range(0, 1) == 1, $urandom_range(NUM_UART, 6), $urandom_range(0, 15), 8'($urandom), 1, '0);
                default: begin
                    ch = $urandom_range(0, NUM_UART - 1);
                    pulse_rx(ch);
                end
            endcase
        end

        repeat (5) @(negedge app_clk);
        chk("queue_drained", exp_q.size(), 32'h0);
        chk("ch_cs_onehot", multi_cs, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_multi_wrapper.md
Name: uart_multi_wrapper

Overview:
- Parametrised N-channel UART aggregator on the register bus.
- Replaces the fixed three-channel wrapper with a generate-instanced array of uart_core.
- Adds:
  - a sequenced register transaction FSM with ack-timeout error;
  - decode error for unmapped blocks;
  - a global register block with per-channel soft reset;
  - RX-activity (wake) interrupt status/mask and an aggregated interrupt output.

Parameters:
- NUM_UART, 4, number of uart_core channels, legal range 1..7.
- ACK_TMO, 32, cycles in ACCESS without channel ack before an error response, legal range 4..255.

Ports:
- app_clk  in  1  single clock for all logic and all channels.
- reset  in  1  synchronous, active-high reset.
- reg_cs  in  1  register access request, held by master until reg_ack.
- reg_wr  in  1  1 = write, 0 = read.
- reg_addr  in  11  [8:6] block select, [5:2] register offset.
- reg_wdata  in  32  write data.
- reg_be  in  4  byte enables.
- reg_rdata  out  32  read data, valid with reg_ack.
- reg_ack  out  1  one-cycle response strobe.
- reg_err  out  1  error qualifier, valid with reg_ack.
- uart_rxd  in  NUM_UART  serial inputs, asynchronous.
- uart_txd  out  NUM_UART  serial outputs.
- uart_irq  out  1  OR of (IRQ_STAT & IRQ_MASK), registered.

Behaviour:
- Reset (reset=1 at a rising app_clk edge):
  - State = IDLE.
  - reg_ack=0, reg_err=0, reg_rdata=0, uart_irq=0.
  - IRQ_STAT=0, IRQ_MASK=0, UART_RST=all ones, so all channels are held in reset until software releases them.
- Channel reset: uart_core arst_n[i] = ~(reset | UART_RST[i]), driven from a flop.
- FSM states and transitions:
  - IDLE: on reg_cs=1, latch sel=reg_addr[8:6], off=reg_addr[5:2], wr, wdata[7:0] and be[0].
    - sel < NUM_UART or sel == 7 -> ACCESS.
    - Otherwise -> RESP with err=1, rdata=0, and no channel cs.
  - ACCESS, channel i: ch_cs[i]=1 with the latched fields; the timeout counter increments each cycle.
    - On ch_ack[i]: capture {24'h0, ch_rdata[i]}, go to RESP with err=0.
    - On counter == ACK_TMO-1 with no ack: drop ch_cs, go to RESP with err=1, rdata=0.
  - ACCESS, global block (sel==7): the register op executes in the first ACCESS cycle, then -> RESP.
  - RESP: reg_ack=1 and reg_err valid for exactly one cycle -> TURN.
  - TURN: reg_cs is ignored for one cycle -> IDLE.
- Latency:
  - Channel read with a 1-cycle uart_core ack: cs seen at cycle 0, ACCESS at cycles 1..2, reg_ack at cycle 3.
  - Global block: reg_ack at cycle 2.
  - Decode error: reg_ack at cycle 1.
- Only one ch_cs bit is ever high. The latched fields are stable for the whole of ACCESS, independent of reg_addr changes.
- Global block, sel=7 (writes take effect only when be[0]=1; reads always return data):
  - off 0 IRQ_STAT: read status; write-1-to-clear.
  - off 1 IRQ_MASK: read/write.
  - off 2 UART_RST: read/write, level-held per-channel reset.
  - off 3 INFO: read-only {16'h0, VERSION[7:0], 4'h0, NUM_UART[3:0]}; writes are ignored, err=0.
  - Other offsets: read 0, write ignored, err=0.
  - Bits >= NUM_UART read as 0 in every register.
- RX activity detection:
  - Per channel: 2-flop synchroniser on uart_rxd[i], then 1->0 edge detect.
  - An edge sets IRQ_STAT[i] even while the channel is in soft reset.
  - Simultaneous edge and W1C on the same bit: the set wins.
- uart_irq: registered, so it updates one cycle after IRQ_STAT/IRQ_MASK change.
- Reset mid-transaction: synchronous reset forces IDLE the next edge. Any pending response is dropped; no reg_ack is issued.

Decomposition:
- Shared package uart_multi_pkg:
  - FSM state enum (IDLE, ACCESS, RESP, TURN).
  - GLB_BLK = 3'd7.
  - Offsets OFF_IRQ_STAT=0, OFF_IRQ_MASK=1, OFF_UART_RST=2, OFF_INFO=3.
  - VERSION = 8'h01.
- Sub-module uart_rx_act_det: synchroniser plus falling-edge pulse, one instance per channel.
- uart_core: instanced NUM_UART times via generate.

Test Plan:
1. After reset, read sel=7 off=3 -> reg_ack at cycle 2, rdata=32'h0000_0104, err=0; UART_RST reads 4'hF.
2. Write UART_RST=0, write ch1 off 0 data 8'h5A, read it back -> rdata=32'h0000_005A, err=0, only ch_cs[1] ever asserted.
3. Access sel=5 with NUM_UART=4 -> reg_ack at cycle 1, err=1, rdata=0, no ch_cs activity.
4. Hold ch2 in soft reset (UART_RST=4'h4) and read ch2 (no ack) -> reg_ack exactly ACK_TMO+1 cycles after cs, err=1; the next transaction completes normally.
5. IRQ_MASK=4'h1, drive a falling edge on uart_rxd[0] -> IRQ_STAT=1 and uart_irq=1 within 4 cycles. W1C 1 in the same cycle as a new edge -> bit stays 1. A later W1C with no edge -> uart_irq=0 one cycle after IRQ_STAT clears.
6. Assert reset during ACCESS -> no reg_ack, IDLE next cycle, all registers at reset values.
